tt_um_up_down_counter: RTL and testbench

TT_UM_UP_DOWN_COUNTER -- requirements
Module: tt_um_up_down_counter

---
 rtl/tt_um_up_down_counter.sv | 65 ++++++
 tb/tb_tt_um_up_down_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tt_um_up_down_counter.sv
// WIDTH-bit up/down counter with synchronous load, combinational terminal-count flag and async-assert/sync-release reset.
// Define UP_DOWN_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module tt_um_up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             set,
    input  logic [WIDTH-1:0] set_value,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] maxCount = '1;
    localparam logic [WIDTH-1:0] stepOne  = WIDTH'(1);

    logic [1:0]       rstSync_q;
    logic             active;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             atTerminal;

    // Two-flop release synchronizer; active rises on the second edge after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign active     = rstSync_q[1];
    assign atTerminal = up_down ? (count_q == maxCount) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (!active) begin
            count_d = '0;
        end else if (set) begin
            count_d = set_value;
        end else if (enable) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
            if (!atTerminal) begin
                count_d = up_down ? (count_q + stepOne) : (count_q - stepOne);
            end
`else
            count_d = up_down ? (count_q + stepOne) : (count_q - stepOne);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = active & enable & ~set & atTerminal;

endmodule

// File: tb/tb_tt_um_up_down_counter.sv
// Scoreboard bench for tt_um_up_down_counter: expected counts are queued when stimulus is driven
// and popped when the registered output settles after the edge.
module tb_tt_um_up_down_counter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             set;
   logic [WIDTH-1:0] set_value;
   logic             up_down;
   logic [WIDTH-1:0] count;
   logic             tc;

   int totalChecks = 0;
   int badChecks   = 0;

   logic [WIDTH-1:0] expQ[$];
   logic [WIDTH-1:0] modelCount;
   logic             modelActive;

   tt_um_up_down_counter #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .set(set),
      .set_value(set_value),
      .up_down(up_down),
      .count(count),
      .tc(tc)
   );

   // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports a mismatch with observed and expected values
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference next-state: reset > set > enable > hold, wrap or saturate at the ends
   function automatic logic [WIDTH-1:0] modelNext(input logic act, input logic en, input logic st,
                                                  input logic [WIDTH-1:0] sv, input logic ud,
                                                  input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] maxVal;
      maxVal = '1;
      if (!act) return '0;
      if (st) return sv;
      if (!en) return cur;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      if (ud && cur == maxVal) return cur;
      if (!ud && cur == '0) return cur;
`endif
      return ud ? WIDTH'(cur + 1) : WIDTH'(cur - 1);
   endfunction

   // Drives one cycle of inputs on the falling edge, checks tc, queues the expected count and checks it after the edge
   task automatic applyStimulus(input logic en, input logic st, input logic [WIDTH-1:0] sv, input logic ud);
      logic             expTc;
      logic [WIDTH-1:0] maxVal;
      logic [WIDTH-1:0] expCount;
      maxVal = '1;
      @(negedge clk);
      enable    = en;
      set       = st;
      set_value = sv;
      up_down   = ud;
      #1;
      expTc = modelActive && en && !st &&
              ((ud && modelCount == maxVal) || (!ud && modelCount == '0));
      checkOutput("tc", 32'(tc), 32'(expTc));
      expQ.push_back(modelNext(modelActive, en, st, sv, ud, modelCount));
      @(posedge clk);
      #1;
      expCount = expQ.pop_front();
      checkOutput("count", 32'(count), 32'(expCount));
      modelCount = expCount;
   endtask

   // Main sequence: reset hold, directed counting and wrap cases, random traffic, mid-count reset
   initial begin
      reset       = 1'b0;
      enable      = 1'b0;
      set         = 1'b0;
      set_value   = '0;
      up_down     = 1'b1;
      modelCount  = '0;
      modelActive = 1'b0;

      #1;
      checkOutput("reset_count", 32'(count), 32'd0);

      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 4'd7, 1'b1);

      @(negedge clk);
      reset       = 1'b1;
      modelActive = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);

      applyStimulus(1'b0, 1'b1, 4'd0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);

      applyStimulus(1'b0, 1'b1, 4'd14, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);

      applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd9, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      applyStimulus(1'b0, 1'b1, 4'd6, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);
      #2;
      reset       = 1'b0;
      modelCount  = '0;
      modelActive = 1'b0;
      #1;
      checkOutput("async_reset_count", 32'(count), 32'd0);
      checkOutput("async_reset_tc", 32'(tc), 32'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

      @(negedge clk);
      reset       = 1'b1;
      modelActive = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
